rr_mux_arb: RTL and testbench

Parametrised, registered N-bit CHANNELS:1 multiplexer with its own arbitration. The select is no longer an external switch.
- Each input channel offers data with a valid/ready handshake.
- The block picks one channel per cycle (fixed-priority or round-robin, runtime selectable) and loads it into a single output register with a valid/ready handshake.
- Sits between multiple producers (e.g. register-file read requesters, bus masters) and one shared consumer.

---
 rtl/mux_pkg.sv | 8 +
 rtl/rr_pick.sv | 35 +++
 rtl/rr_mux_arb.sv | 80 ++++++++
 tb/tb_rr_mux_arb.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/mux_pkg.sv
// mux_pkg: shared types and helpers for the round-robin output mux arbiter
package mux_pkg;
  typedef enum logic {MODE_FIXED = 1'b0, MODE_RR = 1'b1} mode_e;
  typedef enum logic {ST_ARB, ST_LOCKED} lock_st_e;
  function automatic int sel_w(input int c);
    return (c > 1) ? $clog2(c) : 1;
  endfunction
endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational rotating-priority picker (fixed priority when rr_mode=0)
module rr_pick
  import mux_pkg::*;
#(
  parameter int CHANNELS = 32,
  parameter int SEL_W = sel_w(CHANNELS)
) (
  input  logic [CHANNELS-1:0] req,
  input  logic [SEL_W-1:0]    ptr,
  input  logic                rr_mode,
  output logic                gnt_valid,
  output logic [SEL_W-1:0]    gnt_idx
);
  logic [SEL_W-1:0] start, any_i, hi_i;
  logic hi_v;
  assign start = (mode_e'(rr_mode) == MODE_RR) ? ptr : '0;
  // lowest request at/above start wins, else wrap to lowest request overall
  always_comb begin
    gnt_valid = 1'b0;
    any_i = '0;
    hi_v = 1'b0;
    hi_i = '0;
    for (int i = CHANNELS - 1; i >= 0; i--) begin
      if (req[i]) begin
        gnt_valid = 1'b1;
        any_i = SEL_W'(i);
      end
      if (req[i] && i >= int'(start)) begin
        hi_v = 1'b1;
        hi_i = SEL_W'(i);
      end
    end
    gnt_idx = hi_v ? hi_i : any_i;
  end
endmodule

// File: rtl/rr_mux_arb.sv
// rr_mux_arb: registered CHANNELS:1 mux with fixed/round-robin arbitration
// RR_MUX_LOCK_EN adds in_last/out_last and packet locking to one channel.
module rr_mux_arb
  import mux_pkg::*;
#(
  parameter int N = 32,
  parameter int CHANNELS = 32,
  localparam int SEL_W = sel_w(CHANNELS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rr_mode,
  input  logic [CHANNELS-1:0]   in_valid,
  input  logic [CHANNELS*N-1:0] in_data,
  output logic [CHANNELS-1:0]   in_ready,
`ifdef RR_MUX_LOCK_EN
  input  logic [CHANNELS-1:0]   in_last,
  output logic                  out_last,
`endif
  output logic                  out_valid,
  output logic [N-1:0]          out_data,
  output logic [SEL_W-1:0]      out_sel,
  input  logic                  out_ready
);
  logic [SEL_W-1:0] ptr, gnt_idx, ptr_nxt;
  logic [CHANNELS-1:0] req;
  logic gnt_valid, load_en, xfer, adv;
  assign load_en = !out_valid || out_ready;
  assign xfer = load_en && gnt_valid && !rst;
  assign in_ready = xfer ? CHANNELS'(1) << gnt_idx : '0;
  assign ptr_nxt = (gnt_idx == SEL_W'(CHANNELS - 1)) ? '0 : gnt_idx + 1'b1;
`ifdef RR_MUX_LOCK_EN
  lock_st_e st, st_nxt;
  logic [SEL_W-1:0] lock_ch, lock_nxt;
  assign req = (st == ST_LOCKED) ? in_valid & (CHANNELS'(1) << lock_ch) : in_valid;
  assign adv = in_last[gnt_idx];
  always_comb begin
    st_nxt = st;
    lock_nxt = lock_ch;
    if (xfer) begin
      st_nxt = adv ? ST_ARB : ST_LOCKED;
      lock_nxt = gnt_idx;
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      st <= ST_ARB;
      lock_ch <= '0;
      out_last <= 1'b0;
    end else begin
      st <= st_nxt;
      lock_ch <= lock_nxt;
      if (xfer) out_last <= adv;
    end
`else
  assign req = in_valid;
  assign adv = 1'b1;
`endif
  rr_pick #(.CHANNELS(CHANNELS), .SEL_W(SEL_W)) u_pick (
    .req(req),
    .ptr(ptr),
    .rr_mode(rr_mode),
    .gnt_valid(gnt_valid),
    .gnt_idx(gnt_idx)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      out_valid <= 1'b0;
      out_data <= '0;
      out_sel <= '0;
      ptr <= '0;
    end else begin
      if (xfer) begin
        out_valid <= 1'b1;
        out_data <= in_data[int'(gnt_idx)*N +: N];
        out_sel <= gnt_idx;
      end else if (out_ready) out_valid <= 1'b0;
      if (xfer && rr_mode && adv) ptr <= ptr_nxt;
    end
endmodule

// File: tb/tb_rr_mux_arb.sv
// tb_rr_mux_arb: directed self-checking bench (32-channel and 5-channel instances)
module tb_rr_mux_arb;
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;
  logic a_mode, a_ordy, a_ovalid;
  logic [31:0] a_valid, a_ready, a_odata;
  logic [1023:0] a_data;
  logic [4:0] a_osel;
  logic b_mode, b_ordy, b_ovalid;
  logic [4:0] b_valid, b_ready;
  logic [39:0] b_data;
  logic [7:0] b_odata;
  logic [2:0] b_osel;
`ifdef RR_MUX_LOCK_EN
  logic [31:0] a_last;
  logic [4:0] b_last;
  logic a_olast, b_olast;
`endif
  int n_cmp = 0, n_err = 0;
  int exp_a[6] = '{3, 7, 20, 3, 7, 20};
  int exp_b[4] = '{4, 0, 4, 0};

  rr_mux_arb #(.N(32), .CHANNELS(32)) u_a (
    .clk(clk), .rst(rst), .rr_mode(a_mode), .in_valid(a_valid), .in_data(a_data),
    .in_ready(a_ready),
`ifdef RR_MUX_LOCK_EN
    .in_last(a_last), .out_last(a_olast),
`endif
    .out_valid(a_ovalid), .out_data(a_odata), .out_sel(a_osel), .out_ready(a_ordy)
  );
  rr_mux_arb #(.N(8), .CHANNELS(5)) u_b (
    .clk(clk), .rst(rst), .rr_mode(b_mode), .in_valid(b_valid), .in_data(b_data),
    .in_ready(b_ready),
`ifdef RR_MUX_LOCK_EN
    .in_last(b_last), .out_last(b_olast),
`endif
    .out_valid(b_ovalid), .out_data(b_odata), .out_sel(b_osel), .out_ready(b_ordy)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    a_mode = 1'b0; a_ordy = 1'b1; a_valid = 32'h8;
    b_mode = 1'b1; b_ordy = 1'b1; b_valid = '0;
    for (int i = 0; i < 32; i++) a_data[i*32 +: 32] = i * 32'h11;
    for (int i = 0; i < 5; i++) b_data[i*8 +: 8] = 8'(i * 8'h11);
`ifdef RR_MUX_LOCK_EN
    a_last = '1; b_last = '1;
`endif
    #1;
    check("rst_ovalid", a_ovalid, 0);
    check("rst_odata", a_odata, 0);
    check("rst_osel", a_osel, 0);
    check("rst_inready", a_ready, 0);
    tick();
    tick();
    rst = 1'b0;
    a_valid = (32'h1 << 3) | (32'h1 << 7) | (32'h1 << 20);
    #1 check("fix_ready", a_ready, 32'h8);
    for (int k = 0; k < 3; k++) begin
      tick();
      check("fix_sel", a_osel, 3);
      check("fix_data", a_odata, 32'h33);
      check("fix_valid", a_ovalid, 1);
      check("fix_rdy7_20", {a_ready[7], a_ready[20]}, 0);
    end
    a_mode = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      check("rr_sel", a_osel, exp_a[k]);
      check("rr_data", a_odata, exp_a[k] * 32'h11);
      check("rr_valid", a_ovalid, 1);
    end
    a_ordy = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("bp_sel", a_osel, 20);
      check("bp_data", a_odata, 32'h154);
      check("bp_valid", a_ovalid, 1);
      check("bp_ready", a_ready, 0);
    end
    a_ordy = 1'b1;
    #1 check("bp_rel_ready", a_ready, 32'h8);
    tick();
    check("bp_rel_sel", a_osel, 3);
    a_valid = 32'h1 << 7;
    tick();
    check("nobubble_sel", a_osel, 7);
    check("nobubble_valid", a_ovalid, 1);
    a_valid = '0;
    tick();
    check("drain_valid", a_ovalid, 0);
    check("drain_sel", a_osel, 7);
    check("drain_data", a_odata, 32'h77);
    a_valid = 32'h1 << 5;
    tick();
    check("pre_rst_sel", a_osel, 5);
    #2 rst = 1'b1;
    #1;
    check("async_valid", a_ovalid, 0);
    check("async_sel", a_osel, 0);
    check("async_data", a_odata, 0);
    check("async_ready", a_ready, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    tick();
    check("post_rst_sel", a_osel, 5);
    check("post_rst_data", a_odata, 32'h55);
    #2 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    a_valid = (32'h1 << 2) | (32'h1 << 9);
    tick();
    check("ptr0_sel", a_osel, 2);
    a_valid = '0;
`ifdef RR_MUX_LOCK_EN
    a_valid = 32'h1 << 1;
    tick();
    check("lk_pre_sel", a_osel, 1);
    a_valid = 32'h6;
    a_last = '0;
    tick();
    check("lk_b1_sel", a_osel, 2);
    check("lk_b1_last", a_olast, 0);
    a_mode = 1'b0;
    #1 check("lk_hold_ready", a_ready, 32'h4);
    a_mode = 1'b1;
    tick();
    check("lk_b2_sel", a_osel, 2);
    a_last[2] = 1'b1;
    tick();
    check("lk_b3_sel", a_osel, 2);
    check("lk_b3_last", a_olast, 1);
    a_valid = 32'h1 << 1;
    a_last = '1;
    tick();
    check("lk_after_sel", a_osel, 1);
    a_valid = '0;
`endif
    b_valid = 5'b01000;
    tick();
    check("w_first_sel", b_osel, 3);
    check("w_first_data", b_odata, 8'h33);
    b_valid = 5'b10001;
    for (int k = 0; k < 4; k++) begin
      tick();
      check("wrap_sel", b_osel, exp_b[k]);
      check("wrap_data", b_odata, exp_b[k] * 8'h11);
    end
    b_valid = '0;
    tick();
    check("wrap_drain", b_ovalid, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
